// File: rtl/dtc_slave_cmd_rx.sv
// DTC slave command receiver: decodes framed commands from the serial trig line
// into one-cycle strobes, a fast-command code and register-write requests.
//
// state   | meaning
// IDLE    | waiting for a start bit
// CODE    | shifting in the 4-bit command code
// PAYLOAD | shifting in the code-dependent payload
// PARITY  | sampling the even-parity bit
// STOP    | sampling the stop bit and committing the frame
module dtc_slave_cmd_rx #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                dtc_clk,
    input  logic                reset_n,
    input  logic                trig_bit,
    output logic                FeeTrig,
    output logic                rdocmd,
    output logic                abortcmd,
    output logic                FastCmd,
    output logic [7:0]          FastCmdCode,
    output logic                cmd_dv,
    output logic [ADDR_W-1:0]   cmd_addr,
    output logic [DATA_W-1:0]   cmd_data,
    input  logic                cmd_dv_ack,
    output logic                cmd_overrun,
    output logic [ERRCNT_W-1:0] errcnt
);
    localparam int PL_W = ADDR_W + DATA_W;
    localparam logic [3:0] CODE_TRIG  = 4'h1;
    localparam logic [3:0] CODE_RDO   = 4'h2;
    localparam logic [3:0] CODE_ABORT = 4'h3;
    localparam logic [3:0] CODE_FAST  = 4'h8;
    localparam logic [3:0] CODE_WRITE = 4'hA;
    localparam logic [6:0] LEN_FAST   = 7'd8;
    localparam logic [6:0] LEN_WRITE  = 7'(PL_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CODE,
        S_PAYLOAD,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state, state_nx;
    logic [6:0]        bit_cnt;
    logic [3:0]        code;
    logic [3:0]        code_full;
    logic [6:0]        pl_len;
    logic [PL_W-1:0]   payload;
    logic              par_acc;
    logic              armed;
    logic              code_known;
    logic              frame_good;

    // Unknown codes are treated as payload-free so the frame is still consumed.
    function automatic logic [6:0] len_of(input logic [3:0] c);
        case (c)
            CODE_FAST:  len_of = LEN_FAST;
            CODE_WRITE: len_of = LEN_WRITE;
            default:    len_of = 7'd0;
        endcase
    endfunction

    assign code_full  = {code[2:0], trig_bit};
    assign pl_len     = len_of(code);
    assign code_known = code inside {CODE_TRIG, CODE_RDO, CODE_ABORT, CODE_FAST, CODE_WRITE};
    assign frame_good = code_known && !par_acc && !trig_bit;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (trig_bit && armed) state_nx = S_CODE;
            S_CODE:    if (bit_cnt == 7'd3)
                           state_nx = (len_of(code_full) == 7'd0) ? S_PARITY : S_PAYLOAD;
            S_PAYLOAD: if (bit_cnt == pl_len - 7'd1) state_nx = S_PARITY;
            S_PARITY:  state_nx = S_STOP;
            S_STOP:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // armed blocks a line stuck high across reset release from posing as a start bit.
    always_ff @(posedge dtc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bit_cnt <= 7'd0;
            code    <= 4'd0;
            payload <= '0;
            par_acc <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= (state_nx != state) ? 7'd0 : bit_cnt + 7'd1;
            if (!trig_bit) armed <= 1'b1;
            if (state == S_IDLE)
                par_acc <= 1'b0;
            else if (state != S_STOP)
                par_acc <= par_acc ^ trig_bit;
            if (state == S_CODE) code <= code_full;
            if (state == S_PAYLOAD) payload <= {payload[PL_W-2:0], trig_bit};
        end
    end

    always_ff @(posedge dtc_clk or negedge reset_n) begin
        if (!reset_n) begin
            FeeTrig     <= 1'b0;
            rdocmd      <= 1'b0;
            abortcmd    <= 1'b0;
            FastCmd     <= 1'b0;
            FastCmdCode <= 8'd0;
            cmd_dv      <= 1'b0;
            cmd_addr    <= '0;
            cmd_data    <= '0;
            cmd_overrun <= 1'b0;
            errcnt      <= '0;
        end else begin
            FeeTrig     <= 1'b0;
            rdocmd      <= 1'b0;
            abortcmd    <= 1'b0;
            FastCmd     <= 1'b0;
            cmd_overrun <= 1'b0;
            if (cmd_dv && cmd_dv_ack) cmd_dv <= 1'b0;
            if (state == S_STOP) begin
                if (!frame_good) begin
                    if (errcnt != '1) errcnt <= errcnt + 1'b1;
                end else begin
                    case (code)
                        CODE_TRIG:  FeeTrig  <= 1'b1;
                        CODE_RDO:   rdocmd   <= 1'b1;
                        CODE_ABORT: abortcmd <= 1'b1;
                        CODE_FAST: begin
                            FastCmd     <= 1'b1;
                            FastCmdCode <= payload[7:0];
                        end
                        CODE_WRITE: begin
                            // A pending write always blocks the new one, even when acked now.
                            if (cmd_dv) begin
                                cmd_overrun <= 1'b1;
                            end else begin
                                cmd_dv   <= 1'b1;
                                cmd_addr <= payload[PL_W-1 -: ADDR_W];
                                cmd_data <= payload[DATA_W-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_dtc_slave_cmd_rx.sv
// Bench for dtc_slave_cmd_rx: directed scenarios plus random frames, every cycle
// compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_dtc_slave_cmd_rx;
    logic        dtc_clk    = 1'b0;
    logic        reset_n    = 1'b0;
    logic        trig_bit   = 1'b0;
    logic        cmd_dv_ack = 1'b0;
    logic        FeeTrig, rdocmd, abortcmd, FastCmd, cmd_dv, cmd_overrun;
    logic [7:0]  FastCmdCode;
    logic [31:0] cmd_addr, cmd_data;
    logic [15:0] errcnt;
    logic        sm_trig, sm_rdo, sm_abort, sm_fast, sm_dv, sm_ovr;
    logic [7:0]  sm_fc;
    logic [31:0] sm_addr, sm_data;
    logic [2:0]  sm_errcnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  exp_str;   // {trig, rdo, abort, fast, overrun}
    logic        exp_dv;
    logic [31:0] exp_addr, exp_data;
    logic [7:0]  exp_fc;
    int          err_count;
    logic [3:0]  unknown_codes [11] = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9,
                                        4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    always #5 dtc_clk = ~dtc_clk;

    dtc_slave_cmd_rx dut (
        .dtc_clk(dtc_clk), .reset_n(reset_n), .trig_bit(trig_bit),
        .FeeTrig(FeeTrig), .rdocmd(rdocmd), .abortcmd(abortcmd),
        .FastCmd(FastCmd), .FastCmdCode(FastCmdCode),
        .cmd_dv(cmd_dv), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_dv_ack(cmd_dv_ack), .cmd_overrun(cmd_overrun), .errcnt(errcnt)
    );

    // Narrow error counter so saturation is reachable in a short run.
    dtc_slave_cmd_rx #(.ERRCNT_W(3)) dut_small (
        .dtc_clk(dtc_clk), .reset_n(reset_n), .trig_bit(trig_bit),
        .FeeTrig(sm_trig), .rdocmd(sm_rdo), .abortcmd(sm_abort),
        .FastCmd(sm_fast), .FastCmdCode(sm_fc),
        .cmd_dv(sm_dv), .cmd_addr(sm_addr), .cmd_data(sm_data),
        .cmd_dv_ack(cmd_dv_ack), .cmd_overrun(sm_ovr), .errcnt(sm_errcnt)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("strobes", 64'({FeeTrig, rdocmd, abortcmd, FastCmd, cmd_overrun}), 64'(exp_str));
        chk("strobes_small", 64'({sm_trig, sm_rdo, sm_abort, sm_fast, sm_ovr}), 64'(exp_str));
        chk("cmd_dv", 64'(cmd_dv), 64'(exp_dv));
        chk("cmd_addr", 64'(cmd_addr), 64'(exp_addr));
        chk("cmd_data", 64'(cmd_data), 64'(exp_data));
        chk("fast_code", 64'(FastCmdCode), 64'(exp_fc));
        chk("errcnt", 64'(errcnt), 64'(sat(err_count, 65535)));
        chk("errcnt_small", 64'(sm_errcnt), 64'(sat(err_count, 7)));
    endtask

    task automatic model_reset();
        exp_str = '0; exp_dv = 1'b0; exp_addr = '0; exp_data = '0; exp_fc = '0; err_count = 0;
    endtask

    // One line bit per cycle; outputs from the previous cycle are checked first.
    task automatic drive_rst(input logic b, input logic ack, input logic rst);
        @(negedge dtc_clk);
        check_all();
        exp_str    = '0;
        trig_bit   = b;
        cmd_dv_ack = ack;
        reset_n    = rst;
    endtask

    task automatic drive(input logic b, input logic ack);
        drive_rst(b, ack, reset_n);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic gap_ack();
        drive(1'b0, 1'b1);
        exp_dv = 1'b0;
    endtask

    task automatic model_frame(input logic [3:0] c, input logic [63:0] pl,
                               input bit corrupt, input bit ack);
        bit known, prev_dv;
        known   = (c == 4'h1) || (c == 4'h2) || (c == 4'h3) || (c == 4'h8) || (c == 4'hA);
        prev_dv = exp_dv;
        if (ack) exp_dv = 1'b0;
        if (!known || corrupt) begin
            err_count++;
        end else begin
            case (c)
                4'h1: exp_str[4] = 1'b1;
                4'h2: exp_str[3] = 1'b1;
                4'h3: exp_str[2] = 1'b1;
                4'h8: begin exp_str[1] = 1'b1; exp_fc = pl[7:0]; end
                4'hA: if (prev_dv) exp_str[0] = 1'b1;
                      else begin exp_dv = 1'b1; exp_addr = pl[63:32]; exp_data = pl[31:0]; end
                default: ;
            endcase
        end
    endtask

    task automatic send_frame(input logic [3:0] c, input logic [63:0] pl, input bit flip,
                              input bit stop1, input bit ack_stop);
        int   plen;
        logic p;
        plen = (c == 4'h8) ? 8 : (c == 4'hA) ? 64 : 0;
        p = (^c) ^ flip;
        for (int i = plen - 1; i >= 0; i--) p ^= pl[i];
        drive(1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) drive(c[i], 1'b0);
        for (int i = plen - 1; i >= 0; i--) drive(pl[i], 1'b0);
        drive(p, 1'b0);
        drive(stop1, ack_stop);
        model_frame(c, pl, flip || stop1, ack_stop);
    endtask

    initial begin
        logic [3:0]  c;
        logic [63:0] pl;
        bit          flip, stop1, ack_s, risky;
        int          kind, gap;

        model_reset();
        repeat (3) drive(1'b0, 1'b0);
        drive_rst(1'b0, 1'b0, 1'b1);
        idle(3);

        // T1 trigger
        send_frame(4'h1, 64'd0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // T2 register write held until ack
        send_frame(4'hA, {32'h0000_1234, 32'hDEAD_BEEF}, 1'b0, 1'b0, 1'b0);
        idle(20);
        chk("t2_dv_held", 64'(cmd_dv), 64'd1);
        chk("t2_addr", 64'(cmd_addr), 64'h1234);
        chk("t2_data", 64'(cmd_data), 64'hDEAD_BEEF);
        gap_ack();
        idle(2);
        chk("t2_dv_cleared", 64'(cmd_dv), 64'd0);

        // T3 bad frames
        send_frame(4'h1, 64'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        send_frame(4'h5, 64'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        send_frame(4'h2, 64'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t3_errcnt", 64'(errcnt), 64'd3);

        // T4 overrun, then ack colliding with a second write
        send_frame(4'hA, {32'hA5A5_0001, 32'h1111_2222}, 1'b0, 1'b0, 1'b0);
        send_frame(4'hA, {32'hBBBB_0002, 32'h3333_4444}, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("t4_addr_kept", 64'(cmd_addr), 64'hA5A5_0001);
        chk("t4_errcnt", 64'(errcnt), 64'd3);
        send_frame(4'hA, {32'hCCCC_0003, 32'h5555_6666}, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("t4_ack_wins", 64'(cmd_dv), 64'd0);

        // T5 fast command then abort with zero gap
        send_frame(4'h8, 64'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(4'h3, 64'd0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // T6 reset in the middle of a write payload, line held high across release
        drive(1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) drive(c_write_bit(i), 1'b0);
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)), 1'b0);
        drive_rst(1'b1, 1'b0, 1'b0);
        model_reset();
        repeat (2) drive(1'b1, 1'b0);
        drive_rst(1'b1, 1'b0, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        idle(3);
        send_frame(4'h1, 64'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("t6_errcnt", 64'(errcnt), 64'd0);

        // Random frames
        for (int n = 0; n < 80; n++) begin
            kind  = $urandom_range(0, 9);
            pl    = {$urandom, $urandom};
            flip  = ($urandom_range(0, 5) == 0);
            stop1 = ($urandom_range(0, 7) == 0);
            case (kind)
                0:       c = 4'h1;
                1:       c = 4'h2;
                2:       c = 4'h3;
                3, 4:    c = 4'h8;
                5, 6, 7: c = 4'hA;
                default: c = unknown_codes[$urandom_range(0, 10)];
            endcase
            ack_s = exp_dv && ($urandom_range(0, 2) == 0);
            send_frame(c, pl, flip, stop1, ack_s);
            risky = flip || stop1 || (kind >= 8);
            gap   = $urandom_range(risky ? 1 : 0, 3);
            for (int g = 0; g < gap; g++) begin
                if (exp_dv && ($urandom_range(0, 3) == 0)) gap_ack();
                else drive(1'b0, 1'b0);
            end
        end
        idle(2);

        // Saturation of the narrow counter
        for (int n = 0; n < 10; n++) begin
            send_frame(4'hF, 64'd0, 1'b0, 1'b0, 1'b0);
            idle(1);
        end
        idle(2);
        chk("sat_small", 64'(sm_errcnt), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic c_write_bit(input int i);
        logic [3:0] w;
        w = 4'hA;
        return w[i];
    endfunction
endmodule
